vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the character readout path and the host (CPU) bus.
- While the display is active, two fixed slots in each 8-pixel character cell are reserved for fetching the cell's character byte and attribute byte, which are delivered to the pixel generator.
- All other cycles, and all cycles outside the active display, serve host reads and writes through a req/ack handshake.

Parameters:
- ADDR_W, 15, VRAM byte address width.
- CHAR_SLOT, 3'd1, readoutCount value that issues the character fetch.
- ATTR_SLOT, 3'd3, readoutCount value that issues the attribute fetch. Must differ from CHAR_SLOT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- active  in  1  readout active (display cell in progress)
- readoutCount  in  3  pixel index within current cell, from readout module
- cellAddr  in  ADDR_W-1  current character cell index, from readout module
- hostReq  in  1  host request; held high until hostAck
- hostWe  in  1  1 = write, 0 = read; stable while hostReq
- hostAddr  in  ADDR_W  host byte address; stable while hostReq
- hostWData  in  8  host write data
- hostAck  out  1  one-cycle completion pulse
- hostRData  out  8  read data, valid in hostAck cycle
- memAddr  out  ADDR_W  VRAM address
- memWe  out  1  VRAM write enable
- memWData  out  8  VRAM write data
- memRData  in  8  VRAM read data, registered, 1-cycle latency
- fetchData  out  8  fetched byte to pixel generator
- fetchValid  out  1  fetchData valid this cycle
- fetchIsAttr  out  1  0 = character byte, 1 = attribute byte

Behaviour:
- Memory map: character byte at {cellAddr,1'b0}, attribute byte at {cellAddr,1'b1}.
- Reserved cycle: active && (readoutCount==CHAR_SLOT || readoutCount==ATTR_SLOT).
  - Drives memAddr to the char or attr address, with memWe=0.
- Fetch return: in the cycle after a reserved cycle:
  - fetchValid=1, fetchData=memRData.
  - fetchIsAttr=1 if the issuing slot was ATTR_SLOT, else 0.
  - Fetch return is a registered pipeline and is independent of the host FSM.
- Host FSM, two states:
  - IDLE: if hostReq && !reserved cycle, grant. Drive memAddr=hostAddr, memWe=hostWe, memWData=hostWData. Go to ACK.
  - IDLE: if hostReq is high but the cycle is reserved, stay in IDLE with no memory write.
  - ACK: hostAck=1. hostRData=memRData for reads; it is don't-care for writes (implement as memRData). No host grant this cycle. Return to IDLE.
- Host must drop hostReq, or present a new request, in the cycle after hostAck. Earliest next grant is the cycle after ACK.
- Idle memory cycles (no grant, not reserved): memWe=0, memAddr holds its previous value.
- Worst-case grant latency: 2 cycles after hostReq rises (CHAR_SLOT and ATTR_SLOT are never adjacent with defaults). Worst-case for adjacent slot parameters: 3 cycles.
- active falling mid-cell: reserved cycles stop immediately. A fetch already issued still returns next cycle.
- active rising: the fetch schedule follows readoutCount directly, with no resync state.
- Reset, asynchronous and any time: state=IDLE, hostAck=0, hostRData=0, memWe=0, memAddr=0, memWData=0, fetchValid=0, fetchData=0, fetchIsAttr=0.
  - An in-flight host access is dropped with no ack.
  - The host re-issues after reset.
- A write that was issued before reset asserted may have completed in VRAM. This is acceptable.

Decomposition:
- Shared package vga_pkg:
  - VRAM_ADDR_W = 15.
  - Slot constants CHAR_SLOT and ATTR_SLOT.
  - Host FSM state enum {HOST_IDLE, HOST_ACK}.
- pixgen's readoutCount encoding constants also live in vga_pkg.
- One natural sub-module: vram_fetch_pipe. It holds the reserved-slot decode and the one-stage fetch return register (fetchValid/fetchData/fetchIsAttr). The top holds the host FSM and the memory port mux.

Test Plan:
- Reset: hold rst=1 mid-grant with hostReq=1 → all outputs 0; after release, first grant at the first non-reserved cycle; hostAck one cycle later.
- Fetch schedule: active=1, cellAddr=0x0123, readoutCount cycling 0..7 → memAddr=0x0246 at count 1 and 0x0247 at count 3; fetchValid at counts 2 and 4 with fetchIsAttr 0 then 1; fetchData equals preloaded VRAM bytes 0x41 and 0x1F.
- Host write during blanking: active=0, write 0xA5 to 0x7FFF → memWe=1 for exactly one cycle; hostAck the next cycle; a readback returns 0xA5.
- Collision: hostReq rises when readoutCount=CHAR_SLOT with active=1 → no grant that cycle; grant at count 2; hostAck at count 3; the attr fetch at count 3 still occurs with the correct address.
- Back-to-back host: two reads with hostReq held continuously → grants are separated by exactly one ACK cycle; no grant is issued in an ACK cycle.
- active drops at readoutCount=2 → no attr fetch; the char byte already issued returns; the host is granted at the following cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: VRAM geometry, readout slot numbering and host arbiter state.
package vga_pkg;

  localparam int VRAM_ADDR_W = 15;

  // readoutCount runs 0..7 across one 8-pixel character cell
  localparam int CELL_PIXELS = 8;
  localparam logic [2:0] READOUT_FIRST = 3'd0;
  localparam logic [2:0] READOUT_LAST = 3'd7;

  localparam logic [2:0] CHAR_SLOT = 3'd1;
  localparam logic [2:0] ATTR_SLOT = 3'd3;

  typedef enum logic {
    HOST_IDLE = 1'b0,
    HOST_ACK  = 1'b1
  } hostStateT;

endpackage

// File: rtl/vram_fetch_pipe.sv
// Reserved-slot decode for character/attribute fetches and the one-stage return register.
module vram_fetch_pipe
  import vga_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter logic [2:0] CHAR_SLOT_P = CHAR_SLOT,
  parameter logic [2:0] ATTR_SLOT_P = ATTR_SLOT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [2:0]        readoutCount,
  input  logic [ADDR_W-2:0] cellAddr,
  input  logic [7:0]        memRData,
  output logic              reserved,
  output logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchValid,
  output logic [7:0]        fetchData,
  output logic              fetchIsAttr
);

  logic isCharSlot;
  logic isAttrSlot;
  logic pendValid;
  logic pendAttr;

  assign isCharSlot = (readoutCount == CHAR_SLOT_P);
  assign isAttrSlot = (readoutCount == ATTR_SLOT_P);

  // Gated by rst so the memory port is quiet while reset is held.
  assign reserved  = active && (isCharSlot || isAttrSlot) && !rst;
  assign fetchAddr = {cellAddr, isAttrSlot};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendValid <= 1'b0;
      pendAttr  <= 1'b0;
    end else begin
      pendValid <= reserved;
      pendAttr  <= reserved && isAttrSlot;
    end
  end

  // VRAM read data arrives one cycle after the address, so it is forwarded directly.
  assign fetchValid  = pendValid;
  assign fetchIsAttr = pendAttr;
  assign fetchData   = pendValid ? memRData : 8'h00;

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between display fetch slots and the host req/ack bus.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter logic [2:0] CHAR_SLOT_P = CHAR_SLOT,
  parameter logic [2:0] ATTR_SLOT_P = ATTR_SLOT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [2:0]        readoutCount,
  input  logic [ADDR_W-2:0] cellAddr,
  input  logic              hostReq,
  input  logic              hostWe,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [7:0]        hostWData,
  output logic              hostAck,
  output logic [7:0]        hostRData,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [7:0]        memWData,
  input  logic [7:0]        memRData,
  output logic [7:0]        fetchData,
  output logic              fetchValid,
  output logic              fetchIsAttr
);

  // Handshake: hostReq stays high with stable hostWe/hostAddr/hostWData until the
  // single-cycle hostAck; the host drops or replaces the request the cycle after.

  hostStateT         hostState;
  hostStateT         nextState;
  logic              grant;
  logic              reserved;
  logic [ADDR_W-1:0] fetchAddr;
  logic [ADDR_W-1:0] lastAddr;
  logic [7:0]        lastWData;

  vram_fetch_pipe #(
    .ADDR_W      (ADDR_W),
    .CHAR_SLOT_P (CHAR_SLOT_P),
    .ATTR_SLOT_P (ATTR_SLOT_P)
  ) uFetch (
    .clk          (clk),
    .rst          (rst),
    .active       (active),
    .readoutCount (readoutCount),
    .cellAddr     (cellAddr),
    .memRData     (memRData),
    .reserved     (reserved),
    .fetchAddr    (fetchAddr),
    .fetchValid   (fetchValid),
    .fetchData    (fetchData),
    .fetchIsAttr  (fetchIsAttr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hostState <= HOST_IDLE;
    end else begin
      hostState <= nextState;
    end
  end

  always_comb begin
    nextState = hostState;
    grant     = 1'b0;
    case (hostState)
      HOST_IDLE: begin
        if (hostReq && !reserved && !rst) begin
          grant     = 1'b1;
          nextState = HOST_ACK;
        end
      end
      HOST_ACK: begin
        nextState = HOST_IDLE;
      end
      default: begin
        nextState = HOST_IDLE;
      end
    endcase
  end

  // Fetch slots win the port; idle cycles park on the last address and data.
  assign memAddr  = reserved ? fetchAddr : (grant ? hostAddr : lastAddr);
  assign memWe    = grant && hostWe;
  assign memWData = grant ? hostWData : lastWData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastAddr  <= '0;
      lastWData <= 8'h00;
    end else begin
      lastAddr  <= memAddr;
      lastWData <= memWData;
    end
  end

  assign hostAck   = (hostState == HOST_ACK);
  assign hostRData = hostAck ? memRData : 8'h00;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a VRAM model and cycle-stamped expected-event queues.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int AW = VRAM_ADDR_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          active;
  logic [2:0]    readoutCount;
  logic [AW-2:0] cellAddr;
  logic          hostReq;
  logic          hostWe;
  logic [AW-1:0] hostAddr;
  logic [7:0]    hostWData;
  logic          hostAck;
  logic [7:0]    hostRData;
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [7:0]    memWData;
  logic [7:0]    memRData;
  logic [7:0]    fetchData;
  logic          fetchValid;
  logic          fetchIsAttr;

  logic [7:0] vram [0:(1<<AW)-1];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Entries carry the cycle in which the event must appear.
  logic [63:0] exp_fetch_q[$];
  logic [63:0] exp_host_q[$];
  logic [63:0] exp_write_q[$];

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (memWe) vram[memAddr] <= memWData;
    memRData <= vram[memAddr];
  end

  vram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .active       (active),
    .readoutCount (readoutCount),
    .cellAddr     (cellAddr),
    .hostReq      (hostReq),
    .hostWe       (hostWe),
    .hostAddr     (hostAddr),
    .hostWData    (hostWData),
    .hostAck      (hostAck),
    .hostRData    (hostRData),
    .memAddr      (memAddr),
    .memWe        (memWe),
    .memWData     (memWData),
    .memRData     (memRData),
    .fetchData    (fetchData),
    .fetchValid   (fetchValid),
    .fetchIsAttr  (fetchIsAttr)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] f_ent(input int c, input logic a, input logic [7:0] d);
    return {23'd0, c, a, d};
  endfunction

  function automatic logic [63:0] h_ent(input int c, input logic rd, input logic [7:0] d);
    return {23'd0, c, rd, d};
  endfunction

  function automatic logic [63:0] w_ent(input int c, input logic [AW-1:0] a, input logic [7:0] d);
    return {9'd0, c, a, d};
  endfunction

  task automatic tick(input logic act, input logic [2:0] cnt);
    @(posedge clk);
    #1;
    active       = act;
    readoutCount = cnt;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hostAck"}, hostAck, 0);
    chk({tag, "_hostRData"}, hostRData, 0);
    chk({tag, "_memWe"}, memWe, 0);
    chk({tag, "_memAddr"}, memAddr, 0);
    chk({tag, "_memWData"}, memWData, 0);
    chk({tag, "_fetchValid"}, fetchValid, 0);
    chk({tag, "_fetchData"}, fetchData, 0);
    chk({tag, "_fetchIsAttr"}, fetchIsAttr, 0);
  endtask

  // Host read during blanking: grant at once, ack next cycle, drop after ack.
  task automatic host_read(input logic [AW-1:0] a, input logic [7:0] d);
    tick(1'b0, 3'd0);
    hostReq  = 1'b1;
    hostWe   = 1'b0;
    hostAddr = a;
    exp_host_q.push_back(h_ent(cyc + 1, 1'b1, d));
    tick(1'b0, 3'd0);
    tick(1'b0, 3'd0);
    hostReq = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    logic [7:0]  rd;
    if (fetchValid === 1'b1) begin
      if (exp_fetch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_extra cycle=%0d actual=data %0h attr %0b required=no fetch", cyc, fetchData, fetchIsAttr);
      end else begin
        e = exp_fetch_q.pop_front();
        chk("fetch_return", {23'd0, cyc, fetchIsAttr, fetchData}, e);
      end
    end
    if (hostAck === 1'b1) begin
      if (exp_host_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_ack_extra cycle=%0d actual=ack required=no ack", cyc);
      end else begin
        e  = exp_host_q.pop_front();
        rd = e[8] ? hostRData : e[7:0];
        chk("host_ack", {23'd0, cyc, e[8], rd}, e);
      end
    end
    if (memWe === 1'b1) begin
      if (exp_write_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write_extra cycle=%0d actual=addr %0h data %0h required=no write", cyc, memAddr, memWData);
      end else begin
        e = exp_write_q.pop_front();
        chk("mem_write", {9'd0, cyc, memAddr, memWData}, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    active       = 1'b0;
    readoutCount = 3'd0;
    cellAddr     = '0;
    hostReq      = 1'b0;
    hostWe       = 1'b0;
    hostAddr     = '0;
    hostWData    = 8'h00;
    for (int i = 0; i < (1 << AW); i++) vram[i] = 8'h00;
    vram[15'h0246] = 8'h41;
    vram[15'h0247] = 8'h1F;
    vram[15'h1234] = 8'h77;
    vram[15'h0100] = 8'h33;
    vram[15'h0101] = 8'h44;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch schedule over one cell
    cellAddr = 14'h0123;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, k[2:0]);
      if (k == 1 || k == 3) begin
        exp_fetch_q.push_back(f_ent(cyc + 1, (k == 3), (k == 3) ? 8'h1F : 8'h41));
        @(negedge clk);
        chk((k == 3) ? "attr_fetch_addr" : "char_fetch_addr", memAddr, (k == 3) ? 15'h0247 : 15'h0246);
        chk("fetch_no_we", memWe, 0);
      end
    end

    // Host write in blanking, then readback
    tick(1'b0, 3'd0);
    hostReq   = 1'b1;
    hostWe    = 1'b1;
    hostAddr  = 15'h7FFF;
    hostWData = 8'hA5;
    exp_write_q.push_back(w_ent(cyc, 15'h7FFF, 8'hA5));
    exp_host_q.push_back(h_ent(cyc + 1, 1'b0, 8'h00));
    tick(1'b0, 3'd0);
    tick(1'b0, 3'd0);
    hostReq = 1'b0;
    hostWe  = 1'b0;
    host_read(15'h7FFF, 8'hA5);

    // Collision: request arrives on the character slot
    tick(1'b1, 3'd0);
    tick(1'b1, 3'd1);
    hostReq  = 1'b1;
    hostWe   = 1'b0;
    hostAddr = 15'h1234;
    exp_fetch_q.push_back(f_ent(cyc + 1, 1'b0, 8'h41));
    @(negedge clk);
    chk("coll_char_addr", memAddr, 15'h0246);
    chk("coll_no_grant_we", memWe, 0);
    tick(1'b1, 3'd2);
    exp_host_q.push_back(h_ent(cyc + 1, 1'b1, 8'h77));
    @(negedge clk);
    chk("coll_grant_addr", memAddr, 15'h1234);
    tick(1'b1, 3'd3);
    exp_fetch_q.push_back(f_ent(cyc + 1, 1'b1, 8'h1F));
    @(negedge clk);
    chk("coll_attr_addr", memAddr, 15'h0247);
    tick(1'b1, 3'd4);
    hostReq = 1'b0;
    for (int k = 5; k < 8; k++) tick(1'b1, k[2:0]);

    // Back-to-back reads with hostReq held
    tick(1'b0, 3'd0);
    hostReq  = 1'b1;
    hostAddr = 15'h0100;
    exp_host_q.push_back(h_ent(cyc + 1, 1'b1, 8'h33));
    tick(1'b0, 3'd0);
    @(negedge clk);
    chk("b2b_ack_cycle_addr", memAddr, 15'h0100);
    tick(1'b0, 3'd0);
    hostAddr = 15'h0101;
    exp_host_q.push_back(h_ent(cyc + 1, 1'b1, 8'h44));
    @(negedge clk);
    chk("b2b_second_grant_addr", memAddr, 15'h0101);
    tick(1'b0, 3'd0);
    tick(1'b0, 3'd0);
    hostReq = 1'b0;

    // active drops at count 2 with a pending host read
    tick(1'b1, 3'd0);
    tick(1'b1, 3'd1);
    hostReq  = 1'b1;
    hostAddr = 15'h0100;
    exp_fetch_q.push_back(f_ent(cyc + 1, 1'b0, 8'h41));
    tick(1'b0, 3'd2);
    exp_host_q.push_back(h_ent(cyc + 1, 1'b1, 8'h33));
    @(negedge clk);
    chk("drop_grant_addr", memAddr, 15'h0100);
    tick(1'b0, 3'd3);
    @(negedge clk);
    chk("drop_no_attr_addr", memAddr, 15'h0100);
    chk("drop_no_attr_we", memWe, 0);
    tick(1'b0, 3'd4);
    hostReq = 1'b0;
    for (int k = 5; k < 8; k++) tick(1'b0, k[2:0]);

    // Reset asserted in the middle of a write grant
    tick(1'b0, 3'd0);
    hostReq   = 1'b1;
    hostWe    = 1'b1;
    hostAddr  = 15'h0010;
    hostWData = 8'h5C;
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_grant");
    tick(1'b1, 3'd0);
    tick(1'b1, 3'd1);
    @(negedge clk);
    check_zero("rst_held");
    tick(1'b1, 3'd2);
    tick(1'b1, 3'd3);
    rst = 1'b0;
    exp_fetch_q.push_back(f_ent(cyc + 1, 1'b1, 8'h1F));
    @(negedge clk);
    chk("rst_rel_attr_addr", memAddr, 15'h0247);
    chk("rst_rel_no_grant", memWe, 0);
    tick(1'b1, 3'd4);
    exp_write_q.push_back(w_ent(cyc, 15'h0010, 8'h5C));
    exp_host_q.push_back(h_ent(cyc + 1, 1'b0, 8'h00));
    tick(1'b1, 3'd5);
    tick(1'b1, 3'd6);
    hostReq = 1'b0;
    hostWe  = 1'b0;
    tick(1'b1, 3'd7);
    host_read(15'h0010, 8'h5C);

    repeat (3) tick(1'b0, 3'd0);
    @(negedge clk);
    chk("fetch_q_drained", exp_fetch_q.size(), 0);
    chk("host_q_drained", exp_host_q.size(), 0);
    chk("write_q_drained", exp_write_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
